// File: rtl/lock_mod_pkg.sv
// rtl/lock_mod_pkg.sv - shared constants, state encoding and config record for the lock-in modulation path
package lock_mod_pkg;

  localparam int PH_LEN = 2520;
  localparam int HP_W   = 14;
  localparam int PH_W   = 12;
  localparam int SQ_W   = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [HP_W-1:0] hp;
    logic [PH_W-1:0] phase;
    logic [SQ_W-1:0] phase_sq;
    logic [SQ_W-1:0] sqp;
  } mod_cfg_t;

endpackage

// File: rtl/mod_phase_acc.sv
// rtl/mod_phase_acc.sv - modulo phase adder with wrap flag and out-of-range step detection
module mod_phase_acc
  import lock_mod_pkg::*;
#(
  parameter int MOD = PH_LEN
) (
  input  logic [PH_W-1:0] phase_in,
  input  logic [PH_W-1:0] step,
  output logic [PH_W-1:0] phase_out,
  output logic            wrap,
  output logic            step_inv
);

  logic [PH_W:0] sum;

  // Both operands are below MOD, so one conditional subtraction is enough.
  always_comb begin
    step_inv  = (step >= PH_W'(MOD));
    sum       = {1'b0, phase_in} + {1'b0, step};
    phase_out = phase_in;
    wrap      = 1'b0;
    if (!step_inv) begin
      if (sum >= (PH_W+1)'(MOD)) begin
        phase_out = PH_W'(sum - (PH_W+1)'(MOD));
        wrap      = 1'b1;
      end else begin
        phase_out = sum[PH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mod_cfg_sched.sv
// rtl/mod_cfg_sched.sv - stages bus config and applies it on the generator's period boundary, with optional phase sweep
module mod_cfg_sched
  import lock_mod_pkg::*;
#(
  parameter int TMO_W  = 28,
  parameter int PH_LEN = lock_mod_pkg::PH_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [13:0]     cfg_hp,
  input  logic [11:0]     cfg_phase,
  input  logic [31:0]     cfg_phase_sq,
  input  logic [31:0]     cfg_sqp,
  input  logic            sweep_en,
  input  logic [11:0]     sweep_step,
  input  logic [15:0]     sweep_nper,
  input  logic            harmonic_trig,
  input  logic            square_trig,
  output logic [13:0]     hp,
  output logic [11:0]     phase,
  output logic [31:0]     phase_sq,
  output logic [31:0]     sqp,
  output logic            cfg_busy,
  output logic            cfg_applied,
  output logic            cfg_err,
  output logic            cfg_tmo,
  output logic            sweep_wrap
);

  sched_state_e     state_q, state_d;
  mod_cfg_t         cur_q, cur_d;
  mod_cfg_t         stg_q, stg_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]      swp_cnt_q, swp_cnt_d;
  logic             applied_q, applied_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             wrap_q, wrap_d;

  logic             wr_ok;
  logic             trig;
  logic             tmo_hit;
  logic             swp_hit;
  logic [15:0]      nper_eff;
  mod_cfg_t         new_cfg;
  logic [PH_W-1:0]  acc_phase;
  logic             acc_wrap;
  logic             acc_step_inv;

  mod_phase_acc #(.MOD(PH_LEN)) u_phase_acc (
    .phase_in  (cur_q.phase),
    .step      (sweep_step),
    .phase_out (acc_phase),
    .wrap      (acc_wrap),
    .step_inv  (acc_step_inv)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    stg_d     = stg_q;
    tmo_cnt_d = tmo_cnt_q;
    swp_cnt_d = swp_cnt_q;
    applied_d = 1'b0;
    tmo_d     = 1'b0;
    wrap_d    = 1'b0;

    wr_ok    = cfg_we && (cfg_phase < PH_W'(PH_LEN));
    err_d    = cfg_we && !wr_ok;
    // Boundary follows the mode currently running, so a mode switch lands on the old mode's edge.
    trig     = (cur_q.sqp != '0) ? square_trig : harmonic_trig;
    tmo_hit  = (tmo_cnt_q == '1);
    nper_eff = (sweep_nper == 16'd0) ? 16'd1 : sweep_nper;
    swp_hit  = (({1'b0, swp_cnt_q} + 17'd1) >= {1'b0, nper_eff});
    new_cfg  = '{hp: cfg_hp, phase: cfg_phase, phase_sq: cfg_phase_sq, sqp: cfg_sqp};

    if (!sweep_en) begin
      swp_cnt_d = 16'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sweep_en && (cur_q.sqp == '0) && harmonic_trig) begin
          if (swp_hit) begin
            swp_cnt_d = 16'd0;
            if (!acc_step_inv) begin
              cur_d.phase = acc_phase;
              wrap_d      = acc_wrap;
            end
          end else begin
            swp_cnt_d = swp_cnt_q + 16'd1;
          end
        end
        if (wr_ok) begin
          stg_d     = new_cfg;
          tmo_cnt_d = '0;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (trig || tmo_hit) begin
          cur_d     = stg_q;
          applied_d = 1'b1;
          tmo_d     = tmo_hit && !trig;
          swp_cnt_d = 16'd0;
          // A write landing on the boundary becomes the next pending config.
          if (wr_ok) begin
            stg_d     = new_cfg;
            tmo_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (wr_ok) begin
            stg_d = new_cfg;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      stg_q     <= '0;
      tmo_cnt_q <= '0;
      swp_cnt_q <= '0;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      stg_q     <= stg_d;
      tmo_cnt_q <= tmo_cnt_d;
      swp_cnt_q <= swp_cnt_d;
      applied_q <= applied_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      wrap_q    <= wrap_d;
    end
  end

  assign hp          = cur_q.hp;
  assign phase       = cur_q.phase;
  assign phase_sq    = cur_q.phase_sq;
  assign sqp         = cur_q.sqp;
  assign cfg_busy    = (state_q == ST_PEND);
  assign cfg_applied = applied_q;
  assign cfg_err     = err_q;
  assign cfg_tmo     = tmo_q;
  assign sweep_wrap  = wrap_q;

endmodule

// File: tb/tb_mod_cfg_sched.sv
// tb/tb_mod_cfg_sched.sv - self-checking bench for mod_cfg_sched
module tb_mod_cfg_sched;

  localparam int TMO1 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_we = 1'b0;
  logic [13:0] i_hp = '0;
  logic [11:0] i_ph = '0;
  logic [31:0] i_psq = '0;
  logic [31:0] i_sqp = '0;
  logic        i_swen = 1'b0;
  logic [11:0] i_step = '0;
  logic [15:0] i_nper = '0;
  logic        i_ht = 1'b0;
  logic        i_st = 1'b0;

  logic [13:0] hp, t_hp;
  logic [11:0] phase, t_phase;
  logic [31:0] phase_sq, t_phase_sq, sqp, t_sqp;
  logic        busy, applied, err, tmo, wrap;
  logic        t_busy, t_applied, t_err, t_tmo, t_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_cfg_sched #(.TMO_W(TMO1)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(i_we), .cfg_hp(i_hp), .cfg_phase(i_ph),
    .cfg_phase_sq(i_psq), .cfg_sqp(i_sqp), .sweep_en(i_swen), .sweep_step(i_step),
    .sweep_nper(i_nper), .harmonic_trig(i_ht), .square_trig(i_st),
    .hp(hp), .phase(phase), .phase_sq(phase_sq), .sqp(sqp), .cfg_busy(busy),
    .cfg_applied(applied), .cfg_err(err), .cfg_tmo(tmo), .sweep_wrap(wrap)
  );

  mod_cfg_sched #(.TMO_W(4)) u_tmo (
    .clk(clk), .rst(rst), .cfg_we(i_we), .cfg_hp(i_hp), .cfg_phase(i_ph),
    .cfg_phase_sq(i_psq), .cfg_sqp(i_sqp), .sweep_en(i_swen), .sweep_step(i_step),
    .sweep_nper(i_nper), .harmonic_trig(i_ht), .square_trig(i_st),
    .hp(t_hp), .phase(t_phase), .phase_sq(t_phase_sq), .sqp(t_sqp), .cfg_busy(t_busy),
    .cfg_applied(t_applied), .cfg_err(t_err), .cfg_tmo(t_tmo), .sweep_wrap(t_wrap)
  );

  // Reference model: the scheduling rules stated directly, phase arithmetic via modulo.
  typedef struct packed {
    logic [13:0] hp;
    logic [11:0] ph;
    logic [31:0] psq;
    logic [31:0] sqp;
  } mcfg_t;

  mcfg_t m_cur, m_stg;
  bit    m_pend, m_app, m_err, m_tmo, m_wrap;
  int    m_tcnt, m_scnt;

  task automatic model_step();
    mcfg_t w;
    bit ok, trg, hit;
    int n, s;
    w = '{hp: i_hp, ph: i_ph, psq: i_psq, sqp: i_sqp};
    if (rst) begin
      m_cur = '0; m_stg = '0; m_pend = 0; m_tcnt = 0; m_scnt = 0;
      m_app = 0; m_err = 0; m_tmo = 0; m_wrap = 0;
      return;
    end
    ok    = i_we && (i_ph < 2520);
    m_err = i_we && !ok;
    m_app = 0; m_tmo = 0; m_wrap = 0;
    trg   = (m_cur.sqp != 0) ? i_st : i_ht;
    hit   = m_pend && (m_tcnt == (1 << TMO1) - 1);
    if (!i_swen) m_scnt = 0;
    if (m_pend && (trg || hit)) begin
      m_cur = m_stg; m_app = 1; m_tmo = hit && !trg; m_scnt = 0;
      m_pend = ok;
      if (ok) begin m_stg = w; m_tcnt = 0; end
    end else if (m_pend) begin
      m_tcnt++;
      if (ok) m_stg = w;
    end else begin
      if (i_swen && m_cur.sqp == 0 && i_ht) begin
        n = (i_nper == 0) ? 1 : int'(i_nper);
        if (m_scnt + 1 >= n) begin
          m_scnt = 0;
          if (i_step < 2520) begin
            s      = int'(m_cur.ph) + int'(i_step);
            m_wrap = (s >= 2520);
            m_cur.ph = 12'(s % 2520);
          end
        end else begin
          m_scnt++;
        end
      end
      if (ok) begin m_stg = w; m_pend = 1; m_tcnt = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, we, swen, ht, st;
    logic [13:0] hp;
    logic [11:0] ph, step;
    logic [31:0] sqp;
    logic [15:0] nper;
    logic [13:0] e_hp;
    logic [11:0] e_ph;
    logic [31:0] e_sqp;
    bit          e_busy, e_app, e_err, e_wrap;
  } vec_t;

  function automatic vec_t mk(int r, int we, int h, int p, int q, int sw, int stp, int np,
                              int ht, int st, int eh, int ep, int eq, int eb, int ea,
                              int ee, int ew);
    vec_t v;
    v.rst = r[0]; v.we = we[0]; v.hp = 14'(h); v.ph = 12'(p); v.sqp = 32'(q);
    v.swen = sw[0]; v.step = 12'(stp); v.nper = 16'(np); v.ht = ht[0]; v.st = st[0];
    v.e_hp = 14'(eh); v.e_ph = 12'(ep); v.e_sqp = 32'(eq);
    v.e_busy = eb[0]; v.e_app = ea[0]; v.e_err = ee[0]; v.e_wrap = ew[0];
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    //            rst we  hp   ph  sqp sw  stp np ht st |  ehp  eph  esqp b a e w
    vecs.push_back(mk(0, 1,  9,  630, 1000, 0,   0, 0, 0, 0,  9,  630,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0,  9,  630, 1000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  9,  100,    0, 0,   0, 0, 0, 0,  9,  630, 1000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0,  9,  630, 1000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 0, 1,  9,  100,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 0, 0,  9,  100,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  9, 2520,    0, 0,   0, 0, 0, 0,  9,  100,    0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 0, 0,  9,  100,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  5, 2519,    0, 0,   0, 0, 0, 0,  9,  100,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0,  5, 2519,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  5, 2500,    0, 0,   0, 0, 0, 0,  5, 2519,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0,  5, 2500,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 0, 0,  5, 2500,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 1, 0,  5, 2500,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 0, 0,  5, 2500,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 1, 0,  5,   10,    0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 0, 0,  5,   10,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 1, 0,  5,   10,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 2, 1, 0,  5,   40,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,2520, 1, 1, 0,  5,   40,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 0, 1, 0,  5,   70,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  7, 1000,    0, 1,  30, 1, 1, 0,  5,  100,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 1, 1, 0,  7, 1000,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 1,  30, 1, 1, 0,  7, 1030,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,  30, 1, 1, 0,  7, 1030,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 11,  200,    0, 0,   0, 0, 0, 0,  7, 1030,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 12,  300,    0, 0,   0, 0, 1, 0, 11,  200,    0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 0, 0, 11,  200,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0, 12,  300,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 13,  400,    0, 0,   0, 0, 0, 0, 12,  300,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 14,  500,    0, 0,   0, 0, 0, 0, 12,  300,    0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  0,    0,    0, 0,   0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,    0,    0, 0,   0, 0, 1, 0,  0,    0,    0, 0, 0, 0, 0));

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {hp, phase, phase_sq, sqp, busy, applied, err, tmo, wrap}, '0);
    rst = 1'b0;

    // Write held pending with no boundary, then applied by harmonic_trig.
    i_we = 1'b1; i_hp = 14'd9; i_ph = 12'd630; i_sqp = '0; i_psq = '0;
    tick();
    i_we = 1'b0;
    chk("t1_busy_after_write", {busy, applied, hp, phase}, {1'b1, 1'b0, 14'd0, 12'd0});
    for (int k = 0; k < 58; k++) begin
      tick();
      chk($sformatf("t1_hold_%0d", k), {busy, applied, hp, phase}, {1'b1, 1'b0, 14'd0, 12'd0});
    end
    i_ht = 1'b1;
    tick();
    i_ht = 1'b0;
    chk("t1_apply", {busy, applied, hp, phase}, {1'b0, 1'b1, 14'd9, 12'd630});
    tick();
    chk("t1_applied_pulse_end", {busy, applied}, 2'b00);

    // Table-driven sequences: mode switch, rejection, sweep, write-on-boundary, reset mid-pend.
    foreach (vecs[i]) begin
      rst = vecs[i].rst; i_we = vecs[i].we; i_hp = vecs[i].hp; i_ph = vecs[i].ph;
      i_sqp = vecs[i].sqp; i_psq = '0; i_swen = vecs[i].swen; i_step = vecs[i].step;
      i_nper = vecs[i].nper; i_ht = vecs[i].ht; i_st = vecs[i].st;
      tick();
      chk($sformatf("vec%0d_hp", i), hp, vecs[i].e_hp);
      chk($sformatf("vec%0d_phase", i), phase, vecs[i].e_ph);
      chk($sformatf("vec%0d_sqp", i), sqp, vecs[i].e_sqp);
      chk($sformatf("vec%0d_flags", i), {busy, applied, err, wrap},
          {vecs[i].e_busy, vecs[i].e_app, vecs[i].e_err, vecs[i].e_wrap});
    end
    rst = 1'b0; i_we = 1'b0; i_ht = 1'b0; i_st = 1'b0; i_swen = 1'b0;

    // Forced apply on the 4-bit-timeout instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_we = 1'b1; i_hp = 14'd3; i_ph = 12'd50; i_sqp = '0;
    tick();
    i_we = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("tmo_wait_%0d", k), {t_busy, t_applied, t_tmo}, 3'b100);
    end
    tick();
    chk("tmo_forced_apply", {t_busy, t_applied, t_tmo, t_hp, t_phase},
        {1'b0, 1'b1, 1'b1, 14'd3, 12'd50});
    chk("tmo_long_counter_still_pending", {busy, applied, tmo}, 3'b100);
    tick();
    chk("tmo_pulse_end", {t_applied, t_tmo}, 2'b00);

    // Randomized run against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 399) == 0);
      i_we   = ($urandom_range(0, 5) == 0);
      i_hp   = 14'($urandom);
      i_ph   = 12'($urandom_range(0, 2600));
      i_psq  = $urandom;
      i_sqp  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : 32'd0;
      i_step = 12'($urandom_range(0, 2600));
      i_nper = 16'($urandom_range(0, 3));
      if (c % 250 == 0) i_swen = ~i_swen;
      if (c >= 1500 && c < 2100) begin
        i_ht = 1'b0; i_st = 1'b0;
      end else begin
        i_ht = ($urandom_range(0, 3) == 0);
        i_st = ($urandom_range(0, 4) == 0);
      end
      tick();
      chk($sformatf("rand_%0d", c),
          {hp, phase, phase_sq, sqp, busy, applied, err, tmo, wrap},
          {m_cur.hp, m_cur.ph, m_cur.psq, m_cur.sqp, m_pend, m_app, m_err, m_tmo, m_wrap});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
